// File: rtl/acc_core_if.sv
// Word-addressed request/acknowledge memory port used by acc_core.
// The core drives the request side through the master modport; a RAM,
// SPI RAM controller or testbench model answers through the slave modport.
interface acc_core_if #(
  parameter int WIDTH = 16
);
  localparam int AW = WIDTH - 4;

  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/acc_core.sv
// acc_core: parametrised accumulator CPU with zero and carry flags.
// Runs single-step or free-run, and talks to memory over a generic
// req/ack port. Opcode F is an explicit illegal-instruction trap.
module acc_core #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             run,
  output logic             busy,
  output logic             halt,
  output logic             trap,
  output logic [OUT_W-1:0] data_out,
  acc_core_if.master       mem
);

  localparam int AW = WIDTH - 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_TRAP
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] inst;
  logic             z;
  logic             c;

  logic [3:0]       op;
  logic [AW-1:0]    imm;
  logic [WIDTH-1:0] imm_ext;
  logic             is_mem_op;
  logic             xfer_done;
  logic             retire;

  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  logic [AW-1:0]    pc_next;
  logic [WIDTH-1:0] acc_next;
  logic             acc_we;
  logic             c_next;
  logic             c_we;
  logic             out_we;

  assign op        = inst[WIDTH-1 -: 4];
  assign imm       = inst[AW-1:0];
  assign imm_ext   = {4'b0000, imm};
  assign is_mem_op = (op >= OP_LD) && (op <= OP_XOR);
  assign xfer_done = req & mem.ack;

  // Retire happens in EXEC for register-only ops, or on the MEM ack for
  // memory ops; HALT and the illegal opcode never retire.
  assign retire = ((state == S_EXEC) && !is_mem_op && (op != OP_HALT) && (op != OP_ILL)) ||
                  ((state == S_MEM) && xfer_done);

  // The carry/borrow come out of the extra top bit of a WIDTH+1 wide operation.
  assign sum  = {1'b0, acc} + {1'b0, mem.rdata};
  assign diff = {1'b0, acc} - {1'b0, mem.rdata};

  assign mem.req   = req;
  assign mem.we    = we;
  assign mem.addr  = addr;
  assign mem.wdata = wdata;

  // State register; reset drops any pending request at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and bus/status outputs; the bus is only non-zero while requesting.
  always_comb begin
    state_n = state;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    busy    = 1'b1;
    halt    = 1'b0;
    trap    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (step || run) begin
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        req  = 1'b1;
        addr = pc;
        if (mem.ack) begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_n = S_MEM;
        end else if (op == OP_HALT) begin
          state_n = S_HALT;
        end else if (op == OP_ILL) begin
          state_n = S_TRAP;
        end else begin
          state_n = run ? S_FETCH : S_IDLE;
        end
      end
      S_MEM: begin
        req  = 1'b1;
        addr = imm;
        if (op == OP_ST) begin
          we    = 1'b1;
          wdata = acc;
        end
        if (mem.ack) begin
          state_n = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        busy = 1'b0;
        halt = 1'b1;
      end
      S_TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Retire results: new accumulator, carry, output strobe and next pc.
  always_comb begin
    pc_next  = pc + AW'(1);
    acc_next = acc;
    acc_we   = 1'b0;
    c_next   = c;
    c_we     = 1'b0;
    out_we   = 1'b0;
    case (op)
      OP_LDI: begin
        acc_next = imm_ext;
        acc_we   = 1'b1;
      end
      OP_LD: begin
        acc_next = mem.rdata;
        acc_we   = 1'b1;
      end
      OP_ADD: begin
        acc_next = sum[WIDTH-1:0];
        acc_we   = 1'b1;
        c_next   = sum[WIDTH];
        c_we     = 1'b1;
      end
      OP_SUB: begin
        acc_next = diff[WIDTH-1:0];
        acc_we   = 1'b1;
        c_next   = diff[WIDTH];
        c_we     = 1'b1;
      end
      OP_AND: begin
        acc_next = acc & mem.rdata;
        acc_we   = 1'b1;
      end
      OP_OR: begin
        acc_next = acc | mem.rdata;
        acc_we   = 1'b1;
      end
      OP_XOR: begin
        acc_next = acc ^ mem.rdata;
        acc_we   = 1'b1;
      end
      OP_NOT: begin
        acc_next = ~acc;
        acc_we   = 1'b1;
      end
      OP_JMP: begin
        pc_next = imm;
      end
      OP_JZ: begin
        if (z) begin
          pc_next = imm;
        end
      end
      OP_JC: begin
        if (c) begin
          pc_next = imm;
        end
      end
      OP_OUT: begin
        out_we = 1'b1;
      end
      default: begin
        pc_next = pc + AW'(1);
      end
    endcase
  end

  // Architectural registers: instruction latch on fetch ack, everything else on retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= '0;
      acc      <= '0;
      inst     <= '0;
      z        <= 1'b0;
      c        <= 1'b0;
      data_out <= '0;
    end else begin
      if ((state == S_FETCH) && xfer_done) begin
        inst <= mem.rdata;
      end
      if (retire) begin
        pc <= pc_next;
        if (acc_we) begin
          acc <= acc_next;
          z   <= (acc_next == '0);
        end
        if (c_we) begin
          c <= c_next;
        end
        if (out_we) begin
          data_out <= acc[OUT_W-1:0];
        end
      end
    end
  end

endmodule
